shift_arbiter: RTL

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter_pkg.sv | 28 ++
 rtl/shift_arbiter_if.sv | 48 ++++
 rtl/shift_arbiter_shifter.sv | 24 ++
 rtl/shift_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// Purpose: shared types and constants for the shift arbiter slice (op codes, FSM states, widths).
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package shift_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_ILL = 2'b11
  } op_t;

  // EMPTY: result register holds nothing; FULL: result register valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Saturating increment: sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Purpose: bundle of the two requester ports, the response port and grant counters.
// Latency: n/a (wiring only).
// Backpressure: req ready/valid on each requester, rsp_valid/rsp_ready on the result.
// Ports: master = requesters + result consumer (drives requests and rsp_ready);
//        slave  = the arbiter (drives readys, response and counters).
interface shift_arbiter_if;
  import shift_arbiter_pkg::*;

  logic                req0_valid;
  logic                req0_ready;
  logic [DATA_W-1:0]   req0_a;
  logic [SHAMT_W-1:0]  req0_shamt;
  op_t                 req0_op;

  logic                req1_valid;
  logic                req1_ready;
  logic [DATA_W-1:0]   req1_a;
  logic [SHAMT_W-1:0]  req1_shamt;
  op_t                 req1_op;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_id;
  logic                rsp_err;

  logic [CNT_W-1:0]    gnt_cnt0;
  logic [CNT_W-1:0]    gnt_cnt1;

  modport master (
    output req0_valid, req0_a, req0_shamt, req0_op,
    output req1_valid, req1_a, req1_shamt, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_err,
    input  gnt_cnt0, gnt_cnt1
  );

  modport slave (
    input  req0_valid, req0_a, req0_shamt, req0_op,
    input  req1_valid, req1_a, req1_shamt, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_err,
    output gnt_cnt0, gnt_cnt1
  );

endinterface

// File: rtl/shift_arbiter_shifter.sv
// Purpose: combinational 32-bit barrel shifter (SRL, SLL, SRA; illegal op yields zero).
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: a (operand), shamt (shift amount), op (operation), result (shifted value).
module shift_arbiter_shifter
  import shift_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] shamt,
  input  op_t                op,
  output logic [DATA_W-1:0]  result
);

  always_comb begin
    result = '0;
    case (op)
      OP_SRL:  result = a >> shamt;
      OP_SLL:  result = a << shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Purpose: round-robin arbiter between two shift requesters feeding one registered result.
// Latency: 1 cycle from acceptance to rsp_valid; sustains 1 op/cycle when the consumer is ready.
// Backpressure: readys drop to 0 while a result is held and rsp_ready is low; result stays stable.
// Ports: clk, rst_n (async active-low); bus (slave modport): req0/req1 valid-ready requests,
//        rsp valid-ready result with id/err, saturating per-requester grant counters.
module shift_arbiter
  import shift_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  shift_arbiter_if.slave bus
);

  state_t              state_q, state_d;
  logic                armed_q;
  logic                last_gnt_q;
  logic                grant;
  logic                slot_free;
  logic                accept;
  logic                rsp_valid;

  logic [DATA_W-1:0]   win_a;
  logic [SHAMT_W-1:0]  win_shamt;
  op_t                 win_op;
  logic [DATA_W-1:0]   shift_res;

  logic [DATA_W-1:0]   data_q;
  logic                id_q;
  logic                err_q;
  logic [CNT_W-1:0]    cnt0_q;
  logic [CNT_W-1:0]    cnt1_q;

  assign rsp_valid = (state_q == ST_FULL);
  assign slot_free = !rsp_valid || bus.rsp_ready;

  // A lone valid requester wins; on a tie the one that did not win last time goes.
  // With no valid requester the grant idles on requester 0.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_gnt_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  // armed_q keeps both readys low during reset and rises on the first edge after release.
  assign bus.req0_ready = armed_q && slot_free && !grant;
  assign bus.req1_ready = armed_q && slot_free &&  grant;

  assign accept = (bus.req0_valid && bus.req0_ready) ||
                  (bus.req1_valid && bus.req1_ready);

  assign win_a     = grant ? bus.req1_a     : bus.req0_a;
  assign win_shamt = grant ? bus.req1_shamt : bus.req0_shamt;
  assign win_op    = grant ? bus.req1_op    : bus.req0_op;

  shift_arbiter_shifter u_shifter (
    .a      (win_a),
    .shamt  (win_shamt),
    .op     (win_op),
    .result (shift_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  // Accepting while full overwrites the drained result in the same edge (no bubble).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept)             state_d = ST_FULL;
        else if (bus.rsp_ready) state_d = ST_EMPTY;
      end
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Result payload only moves on acceptance, so it holds under backpressure and after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else if (accept) begin
      data_q     <= shift_res;
      id_q       <= grant;
      err_q      <= (win_op == OP_ILL);
      last_gnt_q <= grant;
      if (grant) cnt1_q <= sat_inc(cnt1_q);
      else       cnt0_q <= sat_inc(cnt0_q);
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_err   = err_q;
  assign bus.gnt_cnt0  = cnt0_q;
  assign bus.gnt_cnt1  = cnt1_q;

endmodule
